gvt_arbiter: RTL and testbench
==============================

# gvt_arbiter

Computes the global virtual time (GVT) from the per-tile local virtual times (LVTs). Every GVT period it samples each tile's LVT, reduces them sequentially to the lexicographic minimum of (timestamp, tiebreaker), and broadcasts the result to all tiles. It sits downstream of the per-tile task units and commit queues, which produce the LVTs, and upstream of the commit logic, which consumes the GVT. It is instantiated once, at the top level.

## Interface
Parameters:
- N_TILES, 4: number of tiles (1..16).
- TS_WIDTH, 32: timestamp width.
- TB_WIDTH, 32: tiebreaker width.
- LOG_GVT_PERIOD, 5: log2 of the idle cycles between samples.

Ports:
- clk  in  1  design clock; one clock, all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- pause  in  1  host freeze; while high, no new sample starts.
- lvt_valid  in  N_TILES  per-tile LVT valid.
- lvt_ts  in  N_TILES x TS_WIDTH  per-tile LVT timestamp.
- lvt_tb  in  N_TILES x TB_WIDTH  per-tile LVT tiebreaker.
- gvt_ts  out  TS_WIDTH  current GVT timestamp.
- gvt_tb  out  TB_WIDTH  current GVT tiebreaker.
- gvt_valid  out  1  one-cycle pulse when gvt_ts/gvt_tb are (re)published.
- regress_count  out  8  saturating count of rejected, non-monotonic GVT candidates.

## Operation
- State machine: IDLE, SAMPLE, REDUCE, PUBLISH.
- Reset values: state IDLE, period counter 0, gvt_ts 0, gvt_tb 0, gvt_valid 0, regress_count 0.
- IDLE:
  - The period counter (LOG_GVT_PERIOD bits) increments each cycle while pause=0 and holds while pause=1.
  - When the counter equals 2^LOG_GVT_PERIOD-1, pause=0, and all lvt_valid bits are 1, the next state is SAMPLE.
  - If any lvt_valid bit is 0, the counter holds at its maximum and the check is retried every cycle.
- SAMPLE (1 cycle): all lvt_ts/lvt_tb are captured into a snapshot register array. The candidate register is set to all-ones. The tile index is set to 0.
- REDUCE (N_TILES cycles):
  - Each cycle compares snapshot[index] against the candidate as the unsigned concatenation {ts,tb}.
  - The candidate takes the smaller of the two; on a tie the candidate is kept.
  - The index increments each cycle. After index N_TILES-1 is processed, the next state is PUBLISH.
- PUBLISH (1 cycle):
  - If candidate >= {gvt_ts,gvt_tb}, the GVT outputs load the candidate.
  - Otherwise the GVT outputs hold their value and regress_count increments, saturating at 255.
  - In both cases gvt_valid pulses, the counter clears to 0, and the next state is IDLE.
- pause asserted during SAMPLE, REDUCE or PUBLISH does not abort the update in progress. It only blocks the next sample.
- Snapshot isolation: LVT input changes after SAMPLE do not affect the update in progress.

## Timing
- Let the SAMPLE state occupy cycle t.
- REDUCE occupies cycles t+1 .. t+N_TILES, and PUBLISH occupies cycle t+N_TILES+1.
- The new gvt_ts/gvt_tb and the gvt_valid=1 pulse are visible in cycle t+N_TILES+2, registered.
- The counter clears at the end of PUBLISH, so with all tiles valid and pause=0 the minimum update period is 2^LOG_GVT_PERIOD + N_TILES + 2 cycles.
- Reset mid-operation: every register returns to its reset value asynchronously. No gvt_valid pulse is produced for the interrupted update.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Basic minimum: N_TILES=4, P=5, LVTs (ts,tb) = (50,3),(20,9),(20,4),(70,0), all valid. Required: gvt_valid pulses 38 cycles after reset release, with gvt=(20,4); the next pulse follows 38 cycles later.
- Not-ready hold: lvt_valid=4'b1011 until cycle 100, then all valid. Required: no gvt_valid before cycle 100; the pulse appears 7 cycles after valid rises, i.e. 1 cycle into SAMPLE plus 4 + 1 + 1 cycles.
- Regression rejection: GVT is published as (40,0); the tiles then present a minimum of (30,5). Required: gvt stays (40,0), gvt_valid still pulses, and regress_count goes 0 to 1. Repeat 300 times: regress_count saturates at 255.
- Snapshot isolation: change lvt_ts[1] from 10 to 5 in the first REDUCE cycle. Required: the published GVT uses 10. The following period publishes 5 only if 5 >= the current GVT.
- Pause: assert pause at counter value 10 for 50 cycles. Required: the counter holds at 10 and no pulse occurs; after release, the pulse arrives 21 + 1 + 4 + 2 cycles later. Pause asserted during REDUCE still yields the pending pulse.
- Async reset during REDUCE: assert rst at index 2. Required: gvt outputs immediately become 0, gvt_valid=0, regress_count=0, and no pulse occurs until a full new period has elapsed.

Source files
------------

// File: rtl/gvt_arbiter.sv
// Global virtual time arbiter: periodically snapshots per-tile LVTs, reduces them
// serially to the lexicographic minimum of {ts,tb} and publishes it monotonically.
module gvt_arbiter #(
  parameter int N_TILES        = 4,
  parameter int TS_WIDTH       = 32,
  parameter int TB_WIDTH       = 32,
  parameter int LOG_GVT_PERIOD = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               pause,
  input  logic [N_TILES-1:0]                 lvt_valid,
  input  logic [N_TILES-1:0][TS_WIDTH-1:0]   lvt_ts,
  input  logic [N_TILES-1:0][TB_WIDTH-1:0]   lvt_tb,
  output logic [TS_WIDTH-1:0]                gvt_ts,
  output logic [TB_WIDTH-1:0]                gvt_tb,
  output logic                               gvt_valid,
  output logic [7:0]                         regress_count
);

  localparam int KW    = TS_WIDTH + TB_WIDTH;
  localparam int IDX_W = (N_TILES > 1) ? $clog2(N_TILES) : 1;
  localparam logic [LOG_GVT_PERIOD-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0]          IDX_LAST = IDX_W'(N_TILES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_REDUCE,
    S_PUBLISH
  } state_t;

  state_t                       r_state;
  logic [LOG_GVT_PERIOD-1:0]    r_cnt;
  logic [N_TILES-1:0][KW-1:0]   r_snap;
  logic [KW-1:0]                r_cand;
  logic [IDX_W-1:0]             r_idx;
  logic [TS_WIDTH-1:0]          r_gvt_ts;
  logic [TB_WIDTH-1:0]          r_gvt_tb;
  logic                         r_gvt_valid;
  logic [7:0]                   r_regress;

  logic [KW-1:0] w_snap_key;
  logic [KW-1:0] w_gvt_key;
  logic          w_all_valid;

  assign w_snap_key  = r_snap[r_idx];
  assign w_gvt_key   = {r_gvt_ts, r_gvt_tb};
  assign w_all_valid = &lvt_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_snap      <= '0;
      r_cand      <= '0;
      r_idx       <= '0;
      r_gvt_ts    <= '0;
      r_gvt_tb    <= '0;
      r_gvt_valid <= 1'b0;
      r_regress   <= '0;
    end else begin
      r_gvt_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // At terminal count the counter parks and the launch is retried each cycle
          if (!pause) begin
            if (r_cnt != CNT_MAX)
              r_cnt <= r_cnt + 1'b1;
            else if (w_all_valid)
              r_state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          for (int i = 0; i < N_TILES; i++)
            r_snap[i] <= {lvt_ts[i], lvt_tb[i]};
          r_cand  <= '1;
          r_idx   <= '0;
          r_state <= S_REDUCE;
        end
        S_REDUCE: begin
          if (w_snap_key < r_cand)
            r_cand <= w_snap_key;
          if (r_idx == IDX_LAST)
            r_state <= S_PUBLISH;
          else
            r_idx <= r_idx + 1'b1;
        end
        S_PUBLISH: begin
          // GVT must never move backwards; a smaller candidate is only counted
          if (r_cand >= w_gvt_key)
            {r_gvt_ts, r_gvt_tb} <= r_cand;
          else if (r_regress != 8'hFF)
            r_regress <= r_regress + 8'd1;
          r_gvt_valid <= 1'b1;
          r_cnt       <= '0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gvt_ts        = r_gvt_ts;
  assign gvt_tb        = r_gvt_tb;
  assign gvt_valid     = r_gvt_valid;
  assign regress_count = r_regress;

endmodule

// File: tb/tb_gvt_arbiter.sv
// Directed self-checking bench for gvt_arbiter (N_TILES=4, LOG_GVT_PERIOD=5).
module tb_gvt_arbiter;

  localparam int N  = 4;
  localparam int TW = 32;
  localparam int BW = 32;

  logic                  clk;
  logic                  rst;
  logic                  pause;
  logic [N-1:0]          lvt_valid;
  logic [N-1:0][TW-1:0]  lvt_ts;
  logic [N-1:0][BW-1:0]  lvt_tb;
  logic [TW-1:0]         gvt_ts;
  logic [BW-1:0]         gvt_tb;
  logic                  gvt_valid;
  logic [7:0]            regress_count;

  int n_tests = 0;
  int n_fail  = 0;

  gvt_arbiter #(
    .N_TILES(N), .TS_WIDTH(TW), .TB_WIDTH(BW), .LOG_GVT_PERIOD(5)
  ) dut (
    .clk(clk), .rst(rst), .pause(pause),
    .lvt_valid(lvt_valid), .lvt_ts(lvt_ts), .lvt_tb(lvt_tb),
    .gvt_ts(gvt_ts), .gvt_tb(gvt_tb), .gvt_valid(gvt_valid),
    .regress_count(regress_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    pause = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_lvt(input int t, input logic [TW-1:0] ts, input logic [BW-1:0] tb);
    lvt_ts[t] = ts;
    lvt_tb[t] = tb;
  endtask

  // Steps until gvt_valid is seen or the budget runs out; cnt = edges taken
  task automatic wait_pulse(input int max_cyc, output int cnt, output bit got);
    cnt = 0;
    got = 1'b0;
    while (cnt < max_cyc && !got) begin
      step();
      cnt++;
      if (gvt_valid) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pause = 1'b0; lvt_valid = '1;
    lvt_ts = '0; lvt_tb = '0;
    #1;
    step();
    n_tests++;
    if (gvt_ts !== 0 || gvt_tb !== 0 || gvt_valid !== 1'b0 || regress_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: got ts=%0d tb=%0d v=%b rc=%0d expected all 0",
               gvt_ts, gvt_tb, gvt_valid, regress_count);
    end
  endtask

  task automatic test_basic_minimum();
    int cnt; bit got;
    lvt_valid = '1;
    set_lvt(0, 50, 3); set_lvt(1, 20, 9); set_lvt(2, 20, 4); set_lvt(3, 70, 0);
    do_reset();
    wait_pulse(60, cnt, got);
    n_tests++;
    if (!got || cnt != 38) begin
      n_fail++;
      $display("FAIL basic_first_latency: got=%0b cycles=%0d expected 38", got, cnt);
    end
    n_tests++;
    if (gvt_ts !== 20 || gvt_tb !== 4) begin
      n_fail++;
      $display("FAIL basic_gvt: got (%0d,%0d) expected (20,4)", gvt_ts, gvt_tb);
    end
    // new tile values for the next period; tiebreaker decides among ts=25
    set_lvt(0, 25, 1); set_lvt(1, 25, 0); set_lvt(2, 90, 0); set_lvt(3, 25, 7);
    step();
    n_tests++;
    if (gvt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_pulse_width: gvt_valid=%b expected 0", gvt_valid);
    end
    wait_pulse(60, cnt, got);
    n_tests++;
    if (!got || cnt + 1 != 38) begin
      n_fail++;
      $display("FAIL basic_period: got=%0b cycles=%0d expected 38", got, cnt + 1);
    end
    n_tests++;
    if (gvt_ts !== 25 || gvt_tb !== 0 || regress_count !== 8'd0) begin
      n_fail++;
      $display("FAIL basic_tiebreak: got (%0d,%0d) rc=%0d expected (25,0) rc=0",
               gvt_ts, gvt_tb, regress_count);
    end
  endtask

  task automatic test_not_ready();
    int cnt; bit got; int pulses;
    lvt_valid = 4'b1011;
    set_lvt(0, 50, 3); set_lvt(1, 20, 9); set_lvt(2, 20, 4); set_lvt(3, 70, 0);
    do_reset();
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (gvt_valid) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL not_ready_no_pulse: got %0d pulses expected 0", pulses);
    end
    lvt_valid = 4'b1111;
    wait_pulse(20, cnt, got);
    n_tests++;
    if (!got || cnt != 7 || gvt_ts !== 20 || gvt_tb !== 4) begin
      n_fail++;
      $display("FAIL not_ready_latency: got=%0b cycles=%0d gvt=(%0d,%0d) expected 7 (20,4)",
               got, cnt, gvt_ts, gvt_tb);
    end
  endtask

  task automatic test_regression();
    int cnt; bit got; int missed;
    lvt_valid = '1;
    set_lvt(0, 40, 0); set_lvt(1, 60, 1); set_lvt(2, 40, 3); set_lvt(3, 99, 9);
    do_reset();
    wait_pulse(60, cnt, got);
    n_tests++;
    if (!got || gvt_ts !== 40 || gvt_tb !== 0) begin
      n_fail++;
      $display("FAIL regress_setup: got=%0b gvt=(%0d,%0d) expected (40,0)", got, gvt_ts, gvt_tb);
    end
    // equal candidate republishes without counting a regression
    wait_pulse(60, cnt, got);
    n_tests++;
    if (!got || gvt_ts !== 40 || gvt_tb !== 0 || regress_count !== 8'd0) begin
      n_fail++;
      $display("FAIL regress_equal: got=%0b gvt=(%0d,%0d) rc=%0d expected (40,0) rc=0",
               got, gvt_ts, gvt_tb, regress_count);
    end
    set_lvt(2, 30, 5);
    wait_pulse(60, cnt, got);
    n_tests++;
    if (!got || gvt_ts !== 40 || gvt_tb !== 0 || regress_count !== 8'd1) begin
      n_fail++;
      $display("FAIL regress_reject: got=%0b gvt=(%0d,%0d) rc=%0d expected (40,0) rc=1",
               got, gvt_ts, gvt_tb, regress_count);
    end
    missed = 0;
    for (int i = 1; i < 300; i++) begin
      wait_pulse(60, cnt, got);
      if (!got) missed++;
      if (i == 253) begin
        n_tests++;
        if (regress_count !== 8'd254) begin
          n_fail++;
          $display("FAIL regress_count_254: got %0d expected 254", regress_count);
        end
      end
    end
    n_tests++;
    if (missed != 0 || regress_count !== 8'd255 || gvt_ts !== 40 || gvt_tb !== 0) begin
      n_fail++;
      $display("FAIL regress_saturate: missed=%0d rc=%0d gvt=(%0d,%0d) expected 0 255 (40,0)",
               missed, regress_count, gvt_ts, gvt_tb);
    end
  endtask

  task automatic test_snapshot();
    int cnt; bit got;
    lvt_valid = '1;
    set_lvt(0, 100, 0); set_lvt(1, 10, 0); set_lvt(2, 100, 1); set_lvt(3, 100, 2);
    do_reset();
    repeat (33) step();
    lvt_ts[1] = 32'd5;
    wait_pulse(10, cnt, got);
    n_tests++;
    if (!got || cnt != 5 || gvt_ts !== 10 || gvt_tb !== 0) begin
      n_fail++;
      $display("FAIL snapshot_isolation: got=%0b cycles=%0d gvt=(%0d,%0d) expected 5 (10,0)",
               got, cnt, gvt_ts, gvt_tb);
    end
    wait_pulse(60, cnt, got);
    n_tests++;
    if (!got || gvt_ts !== 10 || regress_count !== 8'd1) begin
      n_fail++;
      $display("FAIL snapshot_next_period: got=%0b gvt_ts=%0d rc=%0d expected 10 rc=1",
               got, gvt_ts, regress_count);
    end
  endtask

  task automatic test_pause();
    int cnt; bit got; int pulses;
    lvt_valid = '1;
    set_lvt(0, 50, 3); set_lvt(1, 20, 9); set_lvt(2, 20, 4); set_lvt(3, 70, 0);
    do_reset();
    wait_pulse(60, cnt, got);
    repeat (10) step();
    pause = 1'b1;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (gvt_valid) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL pause_no_pulse: got %0d pulses expected 0", pulses);
    end
    pause = 1'b0;
    wait_pulse(60, cnt, got);
    n_tests++;
    if (!got || cnt != 28) begin
      n_fail++;
      $display("FAIL pause_resume_latency: got=%0b cycles=%0d expected 28", got, cnt);
    end
    repeat (34) step();
    pause = 1'b1;
    wait_pulse(10, cnt, got);
    n_tests++;
    if (!got || cnt != 4) begin
      n_fail++;
      $display("FAIL pause_in_reduce: got=%0b cycles=%0d expected 4", got, cnt);
    end
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (gvt_valid) pulses++;
    end
    n_tests++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL pause_blocks_next: got %0d pulses expected 0", pulses);
    end
    pause = 1'b0;
  endtask

  task automatic test_async_reset();
    int cnt; bit got;
    lvt_valid = '1;
    set_lvt(0, 40, 0); set_lvt(1, 60, 1); set_lvt(2, 40, 3); set_lvt(3, 99, 9);
    do_reset();
    wait_pulse(60, cnt, got);
    set_lvt(2, 30, 5);
    wait_pulse(60, cnt, got);
    n_tests++;
    if (regress_count !== 8'd1 || gvt_ts !== 40) begin
      n_fail++;
      $display("FAIL areset_setup: rc=%0d gvt_ts=%0d expected rc=1 ts=40", regress_count, gvt_ts);
    end
    repeat (35) step();
    rst = 1'b1;
    #1;
    n_tests++;
    if (gvt_ts !== 0 || gvt_tb !== 0 || gvt_valid !== 1'b0 || regress_count !== 8'd0) begin
      n_fail++;
      $display("FAIL areset_immediate: got ts=%0d tb=%0d v=%b rc=%0d expected all 0",
               gvt_ts, gvt_tb, gvt_valid, regress_count);
    end
    step();
    rst = 1'b0;
    wait_pulse(60, cnt, got);
    n_tests++;
    if (!got || cnt != 38 || gvt_ts !== 30 || gvt_tb !== 5) begin
      n_fail++;
      $display("FAIL areset_restart: got=%0b cycles=%0d gvt=(%0d,%0d) expected 38 (30,5)",
               got, cnt, gvt_ts, gvt_tb);
    end
  endtask

  initial begin
    test_reset();
    test_basic_minimum();
    test_not_ready();
    test_regression();
    test_snapshot();
    test_pause();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
